// File: rtl/cordic_arbiter_pkg.sv
// cordic_pkg: shared widths and FSM state type for cordic_arbiter.
package cordic_pkg;
  localparam int ANGLE_W = 32;
  localparam int Q15_W = 16;
  localparam int FLIP_W = 3;
  typedef enum logic [2:0] {IDLE, CORE_RST, SETTLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: requester-side request/response channel of cordic_arbiter.
interface cordic_arbiter_if #(parameter int N_REQ = 4);
  import cordic_pkg::*;
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [ANGLE_W*N_REQ-1:0] req_angle;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [IW-1:0] rsp_id;
  logic signed [Q15_W-1:0] rsp_sin, rsp_cos;
  logic signed [FLIP_W-1:0] rsp_flip;
  modport master (output req_valid, req_angle, rsp_ready,
                  input req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_flip, rsp_err);
  modport slave (input req_valid, req_angle, rsp_ready,
                 output req_ready, rsp_valid, rsp_id, rsp_sin, rsp_cos, rsp_flip, rsp_err);
endinterface

// File: rtl/cordic_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, with wrap.
module rr_arbiter #(parameter int N = 4) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  logic [N-1:0] cand;
  // Scan farthest-first so the candidate nearest to ptr overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = N'(1) << ((int'(ptr) + k) % N);
      if (|(req & cand)) begin
        gnt = cand;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one cordic_top sin/cos core among N_REQ round-robin requesters.
// Define CORDIC_ARB_TIMEOUT_EN to add a WAIT watchdog (TIMEOUT_CYC) that reports rsp_err.
module cordic_arbiter import cordic_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int RST_CYC = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  cordic_arbiter_if.slave          bus,
  output logic                     core_rst,
  output logic                     core_valid_in,
  output logic [ANGLE_W-1:0]       core_angle,
  input  logic                     core_valid,
  input  logic signed [Q15_W-1:0]  core_sin,
  input  logic signed [Q15_W-1:0]  core_cos,
  input  logic signed [FLIP_W-1:0] core_flip
);
  localparam int IW = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > 8 || RST_CYC < 1 || RST_CYC > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("cordic_arbiter: parameter out of range");
  end
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, idx;
  logic [N_REQ-1:0] gnt;
  logic [ANGLE_W-1:0] sel_angle;
  logic [3:0] cnt;
  logic accept, timeout;
  rr_arbiter #(.N(N_REQ)) u_rr (.req(bus.req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(idx));
  assign bus.req_ready = (state == IDLE && rst) ? gnt : '0;
  assign accept = state == IDLE && |gnt;
  always_comb begin
    sel_angle = '0;
    for (int i = 0; i < N_REQ; i++)
      sel_angle = gnt[i] ? bus.req_angle[ANGLE_W*i +: ANGLE_W] : sel_angle;
  end
`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wcnt;
  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or negedge rst)
    if (!rst) wcnt <= '0;
    else wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
  assign timeout = state == WAIT && wcnt == WW'(TIMEOUT_CYC - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = accept ? CORE_RST : IDLE;
      CORE_RST: state_n = (cnt == '0) ? SETTLE : CORE_RST;
      SETTLE:   state_n = ISSUE;
      ISSUE:    state_n = WAIT;
      WAIT:     state_n = (core_valid || timeout) ? RESP : WAIT;
      RESP:     state_n = bus.rsp_ready ? IDLE : RESP;
      default:  state_n = IDLE;
    endcase
  end
  // Reset holds core_rst high so the core stays quiet while the arbiter is in reset.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr <= '0;
      cnt <= '0;
      core_rst <= 1'b1;
      core_valid_in <= 1'b0;
      core_angle <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_sin <= '0;
      bus.rsp_cos <= '0;
      bus.rsp_flip <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      core_rst <= accept || (state == CORE_RST && cnt != '0);
      core_valid_in <= state == SETTLE;
      cnt <= accept ? 4'(RST_CYC - 1) : cnt - 4'(state == CORE_RST);
      if (accept) begin
        core_angle <= sel_angle;
        bus.rsp_id <= idx;
        rr_ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
      if (state == WAIT && (core_valid || timeout)) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_sin <= core_valid ? core_sin : '0;
        bus.rsp_cos <= core_valid ? core_cos : '0;
        bus.rsp_flip <= core_valid ? core_flip : '0;
        bus.rsp_err <= !core_valid;
      end else if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: cordic_arbiter against a table-lookup core model with a response scoreboard.
module tb_cordic_arbiter;
  import cordic_pkg::*;
  localparam int N = 4, LAT = 6;
  typedef struct packed {logic signed [15:0] s; logic signed [15:0] c; logic signed [2:0] f;} res_t;
  typedef struct {int id; logic [31:0] ang; res_t exp;} vec_t;
  typedef struct {int id; logic [31:0] ang;} sb_t;
  logic clk = 1'b0, rst = 1'b0;
  logic core_rst, core_valid_in, core_valid;
  logic [31:0] core_angle;
  logic signed [15:0] core_sin, core_cos;
  logic signed [2:0] core_flip;
  logic mute = 1'b0, spur = 1'b0, sb_on = 1'b1;
  int cmp = 0, bad = 0, nrsp = 0;
  sb_t q[$];
  vec_t vecs[5];

  cordic_arbiter_if #(.N_REQ(N)) bus();
  cordic_arbiter #(.N_REQ(N), .RST_CYC(1), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .core_rst(core_rst), .core_valid_in(core_valid_in),
    .core_angle(core_angle), .core_valid(core_valid), .core_sin(core_sin), .core_cos(core_cos),
    .core_flip(core_flip));

  always #5 clk = ~clk;

  function automatic res_t core_fn(logic [31:0] a);
    case (a)
      32'h3F800000: return {16'h6BB6, 16'h4528, 3'b001};
      32'h3F000000: return {16'h3D5D, 16'h7055, 3'b010};
      32'h40000000: return {16'h7464, 16'hCABC, 3'b011};
      32'h40400000: return {16'h1210, 16'h8148, 3'b100};
      32'h00000000: return {16'h0000, 16'h7FFF, 3'b110};
      default:      return '0;
    endcase
  endfunction

  // Core model: fixed latency after the start pulse, cleared by core_rst.
  logic [3:0] mc;
  logic [31:0] ma;
  logic mv;
  res_t mr;
  always @(posedge clk) begin
    if (core_rst) begin
      mc <= '0;
      mv <= 1'b0;
    end else begin
      mv <= 1'b0;
      if (core_valid_in) begin
        mc <= 4'(LAT);
        ma <= core_angle;
      end else if (mc != 0) begin
        mc <= mc - 1'b1;
        if (mc == 1 && !mute) begin
          mv <= 1'b1;
          mr <= core_fn(ma);
        end
      end
    end
  end
  assign core_valid = mv | spur;
  assign core_sin = mr.s;
  assign core_cos = mr.c;
  assign core_flip = mr.f;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic check_near(string n, int act, int exp, int tol);
    cmp++;
    if (act > exp + tol || act < exp - tol) begin
      bad++;
      $display("FAIL %s: got %0h want %0h +-%0d", n, act, exp, tol);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    res_t r;
    if (!rst) q.delete();
    else if (sb_on) begin
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) q.push_back('{i, bus.req_angle[32*i +: 32]});
      if (bus.rsp_valid && bus.rsp_ready) begin
        nrsp++;
        if (q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL sb_unexpected: got rsp id %0d want none", bus.rsp_id);
        end else begin
          e = q.pop_front();
          r = core_fn(e.ang);
          check("sb_id", 32'(bus.rsp_id), 32'(e.id));
          check("sb_sin", 32'(bus.rsp_sin), 32'(r.s));
          check("sb_cos", 32'(bus.rsp_cos), 32'(r.c));
          check("sb_flip", 32'(bus.rsp_flip), 32'(r.f));
          check("sb_err", 32'(bus.rsp_err), 32'(0));
        end
      end
    end
  end

  task automatic wait_rsp(string n);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rsp_valid && t < 100);
    if (!bus.rsp_valid) begin
      cmp++;
      bad++;
      $display("FAIL %s: rsp_valid 0 after %0d cycles, want 1", n, t);
    end
  endtask

  task automatic wait_cvi();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!core_valid_in && t < 30);
    if (!core_valid_in) begin
      cmp++;
      bad++;
      $display("FAIL cvi_wait: core_valid_in 0 after %0d cycles, want 1", t);
    end
  endtask

  task automatic do_req(int id, logic [31:0] a);
    int t = 0;
    @(posedge clk);
    #1;
    bus.req_angle[32*id +: 32] = a;
    bus.req_valid[id] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready[id] && t < 50);
    if (!bus.req_ready[id]) begin
      cmp++;
      bad++;
      $display("FAIL grant_wait: req_ready[%0d] 0 after %0d cycles, want 1", id, t);
    end
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n0;
    vecs[0] = '{0, 32'h3F800000, {16'h6BB6, 16'h4528, 3'b001}};
    vecs[1] = '{3, 32'h3F000000, {16'h3D5D, 16'h7055, 3'b010}};
    vecs[2] = '{1, 32'h40000000, {16'h7464, 16'hCABC, 3'b011}};
    vecs[3] = '{2, 32'h40400000, {16'h1210, 16'h8148, 3'b100}};
    vecs[4] = '{2, 32'h00000000, {16'h0000, 16'h7FFF, 3'b110}};
    bus.req_valid = 4'hF;
    bus.req_angle = {32'h40400000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_core_rst", 32'(core_rst), 32'h1);
    check("rst_core_vin", 32'(core_valid_in), 32'h0);
    check("rst_core_angle", core_angle, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("rst_rsp_sin", 32'(bus.rsp_sin), 32'h0);
    check("rst_rsp_cos", 32'(bus.rsp_cos), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_core_rst", 32'(core_rst), 32'h0);
    // Single request from requester 2 with cycle-exact core handshake timing.
    @(posedge clk);
    #1;
    bus.req_angle[64 +: 32] = 32'h3F800000;
    bus.req_valid[2] = 1'b1;
    @(negedge clk);
    check("single_grant", 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    check("c1_core_rst", 32'(core_rst), 32'h1);
    @(negedge clk);
    check("c2_core_rst", 32'(core_rst), 32'h0);
    check("c2_core_vin", 32'(core_valid_in), 32'h0);
    check("c2_core_angle", core_angle, 32'h3F800000);
    @(negedge clk);
    check("c3_core_vin", 32'(core_valid_in), 32'h1);
    @(negedge clk);
    check("c4_core_vin", 32'(core_valid_in), 32'h0);
    wait_rsp("single_rsp");
    check("single_id", 32'(bus.rsp_id), 32'h2);
    check_near("single_sin", int'(bus.rsp_sin), 'h6BB6, 4);
    check_near("single_cos", int'(bus.rsp_cos), 'h4528, 4);
    check("single_err", 32'(bus.rsp_err), 32'h0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    // Table-driven single requests.
    bus.rsp_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      do_req(vecs[v].id, vecs[v].ang);
      wait_rsp("vec_rsp");
      check("vec_id", 32'(bus.rsp_id), 32'(vecs[v].id));
      check("vec_sin", 32'(bus.rsp_sin), 32'(vecs[v].exp.s));
      check("vec_cos", 32'(bus.rsp_cos), 32'(vecs[v].exp.c));
      check("vec_flip", 32'(bus.rsp_flip), 32'(vecs[v].exp.f));
      @(posedge clk);
    end
    // All requesters valid: grants rotate 0,1,2,3,0 from a fresh pointer.
    do_reset();
    bus.req_angle = {32'h40400000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_rsp("rot_rsp");
      check("rot_id", 32'(bus.rsp_id), 32'(k % 4));
      @(posedge clk);
      if (k == 4) begin
        #1;
        bus.req_valid = '0;
      end
    end
    // Backpressure: data held, no grants, next grant one cycle after the handshake.
    bus.rsp_ready = 1'b0;
    do_req(3, 32'h40400000);
    bus.req_angle[0 +: 32] = 32'h3F000000;
    bus.req_valid[0] = 1'b1;
    wait_rsp("bp_rsp");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_id", 32'(bus.rsp_id), 32'h3);
      check("bp_sin", 32'(bus.rsp_sin), 32'(16'sh1210));
      check("bp_cos", 32'(bus.rsp_cos), 32'(16'sh8148));
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_no_grant", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    check("bp_next_grant", 32'(bus.req_ready), 32'h1);
    check("bp_valid_fell", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    wait_rsp("bp_next_rsp");
    check("bp_next_id", 32'(bus.rsp_id), 32'h0);
    @(posedge clk);
    // Reset during WAIT aborts the operation.
    do_req(1, 32'h3F800000);
    wait_cvi();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("abort_core_rst", 32'(core_rst), 32'h1);
    check("abort_core_vin", 32'(core_valid_in), 32'h0);
    check("abort_core_angle", core_angle, 32'h0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("abort_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("abort_req_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("abort_no_stale", 32'(seen), 32'h0);
    do_req(2, 32'h40000000);
    wait_rsp("abort_next_rsp");
    check("abort_next_id", 32'(bus.rsp_id), 32'h2);
    @(posedge clk);
    // Spurious core_valid in IDLE is ignored.
    @(posedge clk);
    #1;
    spur = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("spur_no_rsp", 32'(seen), 32'h0);
    n0 = nrsp;
    do_req(1, 32'h3F000000);
    wait_rsp("spur_rsp");
    check("spur_id", 32'(bus.rsp_id), 32'h1);
    repeat (20) @(negedge clk);
    check("spur_one_rsp", 32'(nrsp - n0), 32'h1);
    // Core never answers.
    sb_on = 1'b0;
    mute = 1'b1;
    bus.rsp_ready = 1'b0;
    do_req(0, 32'h3F800000);
    wait_cvi();
    seen = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    repeat (8) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("to_not_early", 32'(seen), 32'h0);
    @(negedge clk);
    check("to_valid", 32'(bus.rsp_valid), 32'h1);
    check("to_err", 32'(bus.rsp_err), 32'h1);
    check("to_sin", 32'(bus.rsp_sin), 32'h0);
    check("to_cos", 32'(bus.rsp_cos), 32'h0);
    check("to_flip", 32'(bus.rsp_flip), 32'h0);
    check("to_id", 32'(bus.rsp_id), 32'h0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
`else
    repeat (200) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("nto_no_rsp", 32'(seen), 32'h0);
    do_reset();
`endif
    mute = 1'b0;
    sb_on = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
